// File: rtl/axis_lane_resizer_if.sv
// AXI-Stream lane bus for the resizer datapath.
// Lane-granular tdata with per-lane tkeep.
interface axis_lane_resizer_if #(
  parameter int LANE_W = 8,
  parameter int LANES  = 1
) ();
  logic                      tvalid;
  logic                      tready;
  logic [LANES*LANE_W-1:0]   tdata;
  logic [LANES-1:0]          tkeep;
  logic                      tlast;

  modport master (
    output tvalid, tdata, tkeep, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tlast,
    output tready
  );
endinterface

// File: rtl/axis_lane_resizer.sv
// AXI-Stream lane resizer: compacts kept lanes into a
// circular lane buffer and emits packet-bounded beats.
module axis_lane_resizer #(
  parameter int T_DATA_WIDTH = 8,
  parameter int S_KEEP_WIDTH = 3,
  parameter int M_KEEP_WIDTH = 2,
  parameter int DEPTH        = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  axis_lane_resizer_if.slave           s_axis,
  axis_lane_resizer_if.master          m_axis,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         null_last_err
);
  localparam int W  = T_DATA_WIDTH;
  localparam int S  = S_KEEP_WIDTH;
  localparam int M  = M_KEEP_WIDTH;
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW = CW + 1;

  localparam logic [AW-1:0] DEP = AW'(DEPTH);
  localparam logic [AW-1:0] SK  = AW'(S);
  localparam logic [AW-1:0] MK  = AW'(M);

  logic          run;
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] cnt;

  logic [W-1:0]  mem_d [DEPTH];
  logic          mem_l [DEPTH];

  logic [AW-1:0] wp_x;
  logic [AW-1:0] rp_x;
  logic [AW-1:0] cnt_x;

  logic [AW-1:0] off  [S];
  logic [PW-1:0] widx [S];
  logic [AW-1:0] k;

  logic [PW-1:0] ridx [M];
  logic [AW-1:0] n;
  logic [AW-1:0] jl;
  logic [AW-1:0] len;
  logic          hit;
  logic          mv;

  logic [M*W-1:0] od;
  logic [M-1:0]   ok;

  logic          wr;
  logic          rd;
  logic [CW-1:0] cnt_nx;

  function automatic logic [PW-1:0] wrap(
    input logic [AW-1:0] a
  );
    return PW'((a >= DEP) ? a - DEP : a);
  endfunction

  assign wp_x  = {{(AW-PW){1'b0}}, wp};
  assign rp_x  = {{(AW-PW){1'b0}}, rp};
  assign cnt_x = {1'b0, cnt};

  assign s_axis.tready = run && ((DEP - cnt_x) >= SK);

  assign wr = s_axis.tvalid && s_axis.tready;
  assign rd = mv && m_axis.tready;

  // Compact kept lanes: each kept lane gets the next slot after wp.
  always_comb begin
    k = '0;
    for (int i = 0; i < S; i++) begin
      off[i]  = k;
      widx[i] = wrap(wp_x + k);
      if (s_axis.tkeep[i]) k = k + AW'(1);
    end
  end

  // Head scan: stop the beat at the first stored last flag.
  always_comb begin
    n   = (cnt_x >= MK) ? MK : cnt_x;
    hit = 1'b0;
    jl  = MK;
    for (int i = 0; i < M; i++) begin
      ridx[i] = wrap(rp_x + AW'(i));
      if (!hit && (AW'(i) < n) && mem_l[ridx[i]]) begin
        hit = 1'b1;
        jl  = AW'(i + 1);
      end
    end
  end

  assign mv  = hit || (cnt_x >= MK);
  assign len = mv ? jl : '0;

  // Output lanes packed from lane 0, unused lanes forced to zero.
  always_comb begin
    od = '0;
    ok = '0;
    for (int i = 0; i < M; i++) begin
      if (AW'(i) < len) begin
        od[i*W +: W] = mem_d[ridx[i]];
        ok[i]        = 1'b1;
      end
    end
  end

  assign m_axis.tvalid = mv;
  assign m_axis.tdata  = od;
  assign m_axis.tkeep  = ok;
  assign m_axis.tlast  = hit;

  assign cnt_nx = CW'(cnt_x + (wr ? k : '0) - (rd ? jl : '0));
  assign level  = cnt;

  // Lane storage; only the final kept lane carries tlast.
  always_ff @(posedge clk) begin
    if (wr) begin
      for (int i = 0; i < S; i++) begin
        if (s_axis.tkeep[i]) begin
          mem_d[widx[i]] <= s_axis.tdata[i*W +: W];
          mem_l[widx[i]] <= s_axis.tlast && (off[i] == k - AW'(1));
        end
      end
    end
  end

  // Pointers, occupancy, run enable and the null-last pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run           <= 1'b0;
      wp            <= '0;
      rp            <= '0;
      cnt           <= '0;
      null_last_err <= 1'b0;
    end else begin
      run <= 1'b1;
      if (wr) wp <= wrap(wp_x + k);
      if (rd) rp <= wrap(rp_x + jl);
      cnt           <= cnt_nx;
      null_last_err <= wr && (s_axis.tkeep == '0)
                       && s_axis.tlast;
    end
  end
endmodule

// File: tb/tb_axis_lane_resizer.sv
// Directed bench for axis_lane_resizer (3 -> 2 lanes,
// depth 16) with a beat monitor and lane model queue.
module tb_axis_lane_resizer;
  localparam int W = 8;
  localparam int S = 3;
  localparam int M = 2;
  localparam int D = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  axis_lane_resizer_if #(.LANE_W(W), .LANES(S)) s_if ();
  axis_lane_resizer_if #(.LANE_W(W), .LANES(M)) m_if ();

  logic [4:0] level;
  logic       null_last_err;

  axis_lane_resizer #(
    .T_DATA_WIDTH (W),
    .S_KEEP_WIDTH (S),
    .M_KEEP_WIDTH (M),
    .DEPTH        (D)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis        (s_if),
    .m_axis        (m_if),
    .level         (level),
    .null_last_err (null_last_err)
  );

  int checks = 0;
  int failures = 0;
  int null_cnt = 0;

  logic [18:0] mon_q [$];
  logic [7:0]  exp_q [$];

  always #5 clk = ~clk;

  // Collect every handed-off output beat and count error pulses.
  always @(posedge clk) begin
    if (rst_n && m_if.tvalid && m_if.tready)
      mon_q.push_back({m_if.tlast, m_if.tkeep, m_if.tdata});
    if (null_last_err) null_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [23:0] d,
                      input logic [2:0] kp,
                      input logic l);
    int c;
    s_if.tdata  = d;
    s_if.tkeep  = kp;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    c = 0;
    while (!s_if.tready && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (!s_if.tready) chk("send_tmo", 32'(s_if.tready), 1);
    else begin
      @(posedge clk);
      @(negedge clk);
    end
    s_if.tvalid = 1'b0;
  endtask

  task automatic expect_beat(input string tag,
                             input logic [18:0] e);
    int c;
    c = 0;
    while (mon_q.size() == 0 && c < 20) begin
      @(negedge clk);
      c++;
    end
    if (mon_q.size() == 0) chk({tag, "_none"}, 32'(mon_q.size()), 1);
    else chk(tag, 32'(mon_q.pop_front()), 32'(e));
  endtask

  task automatic wait_empty(input string tag);
    int c;
    c = 0;
    while (level != 0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 32'(level), 0);
  endtask

  initial begin
    logic [7:0]  v;
    logic [7:0]  e0;
    logic [7:0]  e1;
    logic [18:0] got;

    s_if.tvalid = 1'b1;
    s_if.tdata  = '0;
    s_if.tkeep  = '1;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;
    rst_n       = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_rdy", 32'(s_if.tready), 0);
      chk("rst_mv", 32'(m_if.tvalid), 0);
      chk("rst_lvl", 32'(level), 0);
    end
    chk("rst_keep", 32'(m_if.tkeep), 0);
    chk("rst_last", 32'(m_if.tlast), 0);
    chk("rst_data", 32'(m_if.tdata), 0);
    chk("rst_err", 32'(null_last_err), 0);

    s_if.tvalid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rdy_pre", 32'(s_if.tready), 0);
    @(negedge clk);
    chk("rdy_up", 32'(s_if.tready), 1);

    m_if.tready = 1'b1;
    send(24'hA2A1A0, 3'b111, 1'b0);
    send(24'hA5A4A3, 3'b111, 1'b1);
    expect_beat("a0", {1'b0, 2'b11, 16'hA1A0});
    expect_beat("a1", {1'b0, 2'b11, 16'hA3A2});
    expect_beat("a2", {1'b1, 2'b11, 16'hA5A4});
    wait_empty("a_lvl");

    send(24'hEEEED0, 3'b001, 1'b1);
    chk("sh_v", 32'(m_if.tvalid), 1);
    chk("sh_keep", 32'(m_if.tkeep), 32'h1);
    chk("sh_last", 32'(m_if.tlast), 1);
    chk("sh_data", 32'(m_if.tdata), 32'h00D0);
    expect_beat("sh", {1'b1, 2'b01, 16'h00D0});

    send(24'hB2EEB0, 3'b101, 1'b1);
    send(24'hC2C1C0, 3'b111, 1'b0);
    expect_beat("b", {1'b1, 2'b11, 16'hB2B0});
    expect_beat("c", {1'b0, 2'b11, 16'hC1C0});
    repeat (3) @(negedge clk);
    chk("c_lvl", 32'(level), 1);
    chk("c_mv", 32'(m_if.tvalid), 0);
    send(24'hEEEEE0, 3'b001, 1'b1);
    expect_beat("e", {1'b1, 2'b11, 16'hE0C2});
    wait_empty("e_lvl");

    send(24'h000000, 3'b000, 1'b0);
    chk("n0_lvl", 32'(level), 0);
    chk("n0_err", 32'(null_last_err), 0);
    send(24'h000000, 3'b000, 1'b1);
    chk("n1_err", 32'(null_last_err), 1);
    chk("n1_lvl", 32'(level), 0);
    repeat (2) @(negedge clk);
    chk("n_cnt", 32'(null_cnt), 1);
    chk("n_out", 32'(mon_q.size()), 0);

    m_if.tready = 1'b0;
    v = 8'h10;
    send({8'hEE, v + 8'd1, v}, 3'b011, 1'b0);
    exp_q.push_back(v);
    exp_q.push_back(v + 8'd1);
    v = v + 8'd2;
    for (int b = 0; b < 4; b++) begin
      send({v + 8'd2, v + 8'd1, v}, 3'b111, 1'b0);
      for (int i = 0; i < 3; i++) exp_q.push_back(v + 8'(i));
      v = v + 8'd3;
    end
    chk("f_lvl", 32'(level), 14);
    chk("f_rdy", 32'(s_if.tready), 0);
    for (int i = 0; i < 5; i++) begin
      chk("hold", {13'd0, m_if.tvalid, m_if.tlast,
                   m_if.tkeep, m_if.tdata},
          {13'd0, 1'b1, 1'b0, 2'b11, 16'h1110});
      @(negedge clk);
    end

    m_if.tready = 1'b1;
    for (int b = 0; b < 40; b++) begin
      send({v + 8'd2, v + 8'd1, v}, 3'b111, b == 39);
      for (int i = 0; i < 3; i++) exp_q.push_back(v + 8'(i));
      v = v + 8'd3;
    end
    wait_empty("f_drain");
    chk("f_beats", 32'(mon_q.size()), 67);
    for (int b = 0; b < 67; b++) begin
      if (mon_q.size() > 0 && exp_q.size() >= 2) begin
        e0  = exp_q.pop_front();
        e1  = exp_q.pop_front();
        got = mon_q.pop_front();
        chk("wrap", 32'(got), 32'({b == 66, 2'b11, e1, e0}));
      end
    end

    m_if.tready = 1'b0;
    send(24'h333231, 3'b111, 1'b0);
    chk("r_lvl", 32'(level), 3);
    chk("r_mv", 32'(m_if.tvalid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ra_lvl", 32'(level), 0);
    chk("ra_mv", 32'(m_if.tvalid), 0);
    chk("ra_rdy", 32'(s_if.tready), 0);
    chk("ra_data", 32'(m_if.tdata), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axis_lane_resizer.md
# axis_lane_resizer

Parametrised AXI-Stream width converter for the resizer datapath. It accepts S_KEEP_WIDTH-lane beats, compacts away null lanes (tkeep=0), and stores the kept lanes in a lane-granular circular buffer. It emits M_KEEP_WIDTH-lane beats and never merges lanes from two packets into one output beat. Each side has a full valid/ready handshake; occupancy and error status are exported for the stream control logic.

## Interface
Parameters:
- T_DATA_WIDTH, 8: bits per lane.
- S_KEEP_WIDTH, 3: slave lanes per beat, ≥1.
- M_KEEP_WIDTH, 2: master lanes per beat, ≥1.
- DEPTH, 16: buffer capacity in lanes. Must be ≥ S_KEEP_WIDTH+M_KEEP_WIDTH. Need not be a power of two.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- s_tvalid  in  1  slave beat valid.
- s_tready  out  1  slave beat accepted when high together with s_tvalid.
- s_tdata  in  S_KEEP_WIDTH*T_DATA_WIDTH  lane i occupies bits [i*T_DATA_WIDTH +: T_DATA_WIDTH].
- s_tkeep  in  S_KEEP_WIDTH  per-lane keep; any pattern is legal.
- s_tlast  in  1  last beat of packet.
- m_tvalid  out  1  master beat valid.
- m_tready  in  1  downstream ready.
- m_tdata  out  M_KEEP_WIDTH*T_DATA_WIDTH  output lanes, packed from lane 0.
- m_tkeep  out  M_KEEP_WIDTH  thermometer code: low n bits set.
- m_tlast  out  1  beat ends a packet.
- level  out  $clog2(DEPTH+1)  lanes currently stored.
- null_last_err  out  1  one-cycle pulse: accepted beat had s_tlast=1 and s_tkeep=0.

## Operation
- Storage: DEPTH entries of {data, last}, with write pointer wp, read pointer rp and lane counter cnt. Pointers wrap from DEPTH-1 to 0 by compare, not by power-of-two truncation.
- Write:
  - On s_tvalid&&s_tready, the kept lanes (popcount k of s_tkeep) are written in ascending lane order to wp, wp+1, … (mod DEPTH). wp advances by k.
  - The entry written last gets last=s_tlast. All other entries get last=0.
- Null beats:
  - s_tkeep=0 and s_tlast=0: the beat is accepted and discarded.
  - s_tkeep=0 and s_tlast=1: the beat is accepted and discarded, and null_last_err pulses. No entry is modified.
- s_tready = run && (DEPTH-cnt ≥ S_KEEP_WIDTH). This is conservative and independent of s_tkeep. run is a flop that clears on reset and sets on the first clk edge after rst_n rises.
- Output beat formation:
  - n = min(cnt, M_KEEP_WIDTH).
  - j = index (0-based from rp) of the first entry with last=1 among the first n entries. If none exists, j is invalid.
  - m_tvalid = 1 if j is valid, or if cnt ≥ M_KEEP_WIDTH.
  - Beat length L = j+1 if j is valid, else M_KEEP_WIDTH.
  - m_tdata lane i = entry rp+i for i<L. Unused lanes drive 0.
  - m_tkeep = (1<<L)-1. m_tlast = j valid.
- Read: on m_tvalid&&m_tready, rp advances by L (mod DEPTH).
- Count: cnt_next = cnt + k_written − L_read. Simultaneous read and write in one cycle are both honoured.
- Residual lanes: a packet tail shorter than M_KEEP_WIDTH without last waits in the buffer until more lanes arrive. It is never flushed spontaneously.
- level = cnt.

## Timing
- Reset (rst_n low, asynchronous): wp=rp=cnt=0 and run=0. Outputs: s_tready=0, m_tvalid=0, m_tkeep=0, m_tlast=0, m_tdata=0, level=0, null_last_err=0. Storage contents need not be reset.
- s_tready rises on the first clk edge after rst_n deasserts.
- Latency: lanes written at edge N can appear on m_* in the cycle after edge N. Minimum latency is one cycle; there is no combinational s_*→m_* path.
- s_tready depends only on registered state. It does not see frees from the same-cycle read: a full buffer drained at edge N raises s_tready after edge N.
- AXI hold rule: while m_tvalid && !m_tready, m_tdata/m_tkeep/m_tlast/m_tvalid stay stable. Writes cannot alter the head L entries.
- Reset mid-packet: all stored lanes are discarded. Outputs take their reset values immediately and asynchronously.
- Pointer wrap: a write or read spanning DEPTH-1→0 splits correctly across the boundary.
- Throughput: with m_tready held high and an input duty cycle at or below M/S, there are no stalls.

## Test plan
- Reset and idle: hold rst_n low 3 cycles with s_tvalid=1. Require s_tready=0, m_tvalid=0 and level=0. After release, s_tready=1 on the next edge.
- 3→2 conversion: send beats {A0,A1,A2} keep=111 last=0, then {A3,A4,A5} keep=111 last=1, with m_tready=1. Require the output sequence {A0,A1}k=11, {A2,A3}k=11, {A4,A5}k=11 last=1, and level back to 0.
- Compaction and packet boundary: send keep=101 {B0,x,B2} last=1, then keep=111 {C0,C1,C2} last=0. Require {B0,B2}k=11 last=1, then {C0,C1}k=11. C2 stays buffered with level=1 and m_tvalid=0.
- Short packet: send keep=001 {D0} last=1. Require {D0} with m_tkeep=01 and m_tlast=1 one cycle after acceptance.
- Full and backpressure with wrap: DEPTH=16, m_tready=0, stream full beats. Require s_tready to fall at level=14 (free 2<3). Hold m_tready=0 for 5 cycles and check m_* is stable. Then set m_tready=1 and stream 40 beats. Check ordered data across pointer wrap, and no loss or duplication.
- Null beats: s_tkeep=0 with last=0, then s_tkeep=0 with last=1. Both are accepted and level is unchanged. null_last_err pulses exactly once, for the second beat.
